// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the mem_bus arbiter slice: FSM state encoding,
//   fixed port roles and the mem_bus transfer size codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMPLETE = 2'd2,
        RELEASE  = 2'd3
    } arb_state_t;

    // Port roles in the default 3-port build.
    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;
    localparam int PORT_DEBUG = 2;

    // Transfer size codes understood by mem_bus.
    localparam logic [2:0] NB_BYTE = 3'd1;
    localparam logic [2:0] NB_HALF = 3'd2;
    localparam logic [2:0] NB_WORD = 3'd4;

    // Port index width; covers up to 4 requesters.
    localparam int PTR_W = 2;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin selector. Scans req starting at rr_ptr and
//   wrapping modulo NUM_PORTS; the first set bit wins.
// Ports
//   req     in  NUM_PORTS  request levels
//   rr_ptr  in  PTR_W      highest-priority port index
//   winner  out NUM_PORTS  one-hot winner, 0 when no request
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] winner
);

    localparam logic [PTR_W:0] NP = (PTR_W + 1)'(NUM_PORTS);

    logic [PTR_W:0] idx;
    logic           found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (idx >= NP) idx = idx - NP;
            if (!found && req[idx[PTR_W-1:0]]) begin
                winner[idx[PTR_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the serial mem_bus between NUM_PORTS requesters (0 = instruction
//   fetch, 1 = load/store, 2 = debug loader). Round-robin grant; the winner's
//   command is frozen in registers and replayed to mem_bus using the level
//   start_request/request_done handshake.
//
//   Handshake: a requester holds req[p] (and its payload) high until it sees
//   done[p]; it then drops req[p], after which done[p] falls. mem_bus side:
//   mem_start_request stays high until mem_request_done is seen; the arbiter
//   then waits for mem_request_done to fall before the next grant.
//
// Build option: MEM_ARB_TIMEOUT_EN adds an ISSUE watchdog of TIMEOUT_CYCLES
//   cycles that finishes the transfer with err=1 and rdata=0. Without it err
//   is tied low and ISSUE waits indefinitely.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req/req_is_write           per-port request level and store flag
//   req_num_bytes/addr/wdata   per-port packed payload
//   done, rdata, err           per-port completion, read data, timeout flag
//   grant                      one-hot current owner, 0 when idle
//   mem_*                      mem_bus command and response
//   state_dbg                  current FSM state (arb_state_t encoding)
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 3,
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        req_is_write,
    input  logic [3*NUM_PORTS-1:0]      req_num_bytes,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0]     req_wdata,
    output logic [NUM_PORTS-1:0]        done,
    output logic [31:0]                 rdata,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        err,
    output logic                        mem_start_request,
    output logic                        mem_is_write,
    output logic [2:0]                  mem_num_bytes,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_request_done,
    input  logic [31:0]                 mem_fetched_value,
    output logic [1:0]                  state_dbg
);

    if (NUM_PORTS < 2 || NUM_PORTS > 4) begin : g_bad_ports
        $error("mem_bus_arbiter: NUM_PORTS must be 2..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 4095) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be 1..4095");
    end

    arb_state_t           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic                 abandoned;
    logic [NUM_PORTS-1:0] win_oh;

    // Payload of the current winner, selected by one-hot mux.
    logic [PTR_W-1:0]  win_idx;
    logic              sel_wr;
    logic [2:0]        sel_nb;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (win_oh)
    );

    always_comb begin
        win_idx   = '0;
        sel_wr    = 1'b0;
        sel_nb    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win_oh[i]) begin
                win_idx   = PTR_W'(i);
                sel_wr    = req_is_write[i];
                sel_nb    = req_num_bytes[i*3 +: 3];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

    // The requester still wants the answer: it has not dropped req at any
    // point since the grant.
    logic xfer_live;
    assign xfer_live = req[grant_idx] && !abandoned;

    assign state_dbg = state;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [11:0] TO_LAST = 12'(TIMEOUT_CYCLES - 1);
    logic [11:0] to_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant_idx         <= '0;
            abandoned         <= 1'b0;
            grant             <= '0;
            done              <= '0;
            rdata             <= '0;
            mem_start_request <= 1'b0;
            mem_is_write      <= 1'b0;
            mem_num_bytes     <= '0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err               <= 1'b0;
            to_cnt            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant         <= win_oh;
                        grant_idx     <= win_idx;
                        mem_is_write  <= sel_wr;
                        mem_num_bytes <= sel_nb;
                        mem_addr      <= sel_addr;
                        mem_wdata     <= sel_wdata;
                        abandoned     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                        err           <= 1'b0;
                        to_cnt        <= '0;
`endif
                        state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Start is raised one cycle after the grant, giving the
                    // two-cycle req-to-start latency.
                    mem_start_request <= 1'b1;
                    if (!req[grant_idx]) abandoned <= 1'b1;
                    if (mem_start_request && mem_request_done) begin
                        mem_start_request <= 1'b0;
                        if (xfer_live) begin
                            rdata <= mem_fetched_value;
                            done  <= grant;
                            state <= COMPLETE;
                        end else begin
                            // SPI transfer finished but nobody is waiting.
                            state <= RELEASE;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (mem_start_request && to_cnt == TO_LAST) begin
                        mem_start_request <= 1'b0;
                        if (xfer_live) begin
                            rdata <= '0;
                            err   <= 1'b1;
                            done  <= grant;
                            state <= COMPLETE;
                        end else begin
                            state <= RELEASE;
                        end
                    end else if (mem_start_request) begin
                        to_cnt <= to_cnt + 12'd1;
                    end
`endif
                end

                COMPLETE: begin
                    if (!req[grant_idx]) begin
                        done  <= '0;
                        state <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (!mem_request_done) begin
                        grant  <= '0;
                        rr_ptr <= (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                       : grant_idx + 1'b1;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter with a small mem_bus responder model.
//   Define MEM_ARB_TIMEOUT_EN for both files to exercise the watchdog.
module tb_mem_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 18;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, req_is_write;
    logic [3*N-1:0]  req_num_bytes;
    logic [AW*N-1:0] req_addr;
    logic [32*N-1:0] req_wdata;
    logic [N-1:0]    done, grant;
    logic [31:0]     rdata;
    logic            err;
    logic            mem_start_request, mem_is_write;
    logic [2:0]      mem_num_bytes;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_request_done;
    logic [31:0]     mem_fetched_value;
    logic [1:0]      state_dbg;

    mem_bus_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req               (req),
        .req_is_write      (req_is_write),
        .req_num_bytes     (req_num_bytes),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .done              (done),
        .rdata             (rdata),
        .grant             (grant),
        .err               (err),
        .mem_start_request (mem_start_request),
        .mem_is_write      (mem_is_write),
        .mem_num_bytes     (mem_num_bytes),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_request_done  (mem_request_done),
        .mem_fetched_value (mem_fetched_value),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Scoreboard of expected grant order.
    logic [N-1:0] exp_q[$];

    // ---------------- mem_bus responder model ----------------
    int          model_lat   = 4;
    bit          model_en    = 1'b1;
    logic [31:0] model_val   = 32'h0;
    int          model_cnt   = 0;
    int          xfers       = 0;
    int          start_cycles = 0;
    logic        log_wr;
    logic [2:0]  log_nb;
    logic [AW-1:0] log_addr;
    logic [31:0] log_wdata;

    initial begin
        mem_request_done  = 1'b0;
        mem_fetched_value = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_start_request) start_cycles++;
            if (!mem_start_request) begin
                model_cnt        = 0;
                mem_request_done = 1'b0;
            end else if (!mem_request_done && model_en) begin
                model_cnt++;
                if (model_cnt >= model_lat) begin
                    mem_request_done  = 1'b1;
                    mem_fetched_value = model_val;
                    log_wr            = mem_is_write;
                    log_nb            = mem_num_bytes;
                    log_addr          = mem_addr;
                    log_wdata         = mem_wdata;
                    xfers++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic wr, input logic [2:0] nb,
                            input logic [AW-1:0] addr, input logic [31:0] wd);
        req_is_write[p]         = wr;
        req_num_bytes[p*3 +: 3] = nb;
        req_addr[p*AW +: AW]    = addr;
        req_wdata[p*32 +: 32]   = wd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done_port(input int p, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done[p]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_start_request) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (grant == '0 && state_dbg == 2'd0) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL reset_grant got=%b exp=000", grant); end
        vectors++; if (done !== 3'b000) begin miscompares++; $display("FAIL reset_done got=%b exp=000", done); end
        vectors++; if (mem_start_request !== 1'b0) begin miscompares++; $display("FAIL reset_start got=%b exp=0", mem_start_request); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
        vectors++; if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_single_read();
        bit ok;
        model_lat = 5;
        model_val = 32'h1234_5678;
        set_port(0, 1'b0, 3'd4, 18'h00010, 32'h0);
        req[0] = 1'b1;
        @(negedge clk);
        vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL sr_grant got=%b exp=001", grant); end
        vectors++; if (mem_start_request !== 1'b0) begin miscompares++; $display("FAIL sr_start_early got=%b exp=0", mem_start_request); end
        @(negedge clk);
        vectors++; if (mem_start_request !== 1'b1) begin miscompares++; $display("FAIL sr_start_lat got=%b exp=1", mem_start_request); end
        vectors++; if (mem_addr !== 18'h00010 || mem_num_bytes !== 3'd4) begin miscompares++; $display("FAIL sr_payload got=%h/%0d exp=00010/4", mem_addr, mem_num_bytes); end
        wait_done_port(0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sr_done_timeout got=no_done exp=done"); end
        vectors++; if (rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL sr_rdata got=%h exp=12345678", rdata); end
        vectors++; if (done !== 3'b001) begin miscompares++; $display("FAIL sr_done got=%b exp=001", done); end
        repeat (3) @(negedge clk);
        vectors++; if (done !== 3'b001) begin miscompares++; $display("FAIL sr_done_hold got=%b exp=001", done); end
        req[0] = 1'b0;
        @(negedge clk);
        vectors++; if (done !== 3'b000) begin miscompares++; $display("FAIL sr_done_drop got=%b exp=000", done); end
        wait_idle(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sr_idle got=%b exp=000", grant); end
    endtask

    task automatic test_contention();
        bit ok;
        logic [N-1:0] g;
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        model_lat = 3;
        for (int p = 0; p < N; p++) set_port(p, 1'b0, 3'd4, AW'(18'h100 * (p + 1)), 32'h0);
        rst_n = 1'b1;
        req   = 3'b111;
        for (int r = 0; r < 6; r++) exp_q.push_back(N'(1 << (r % 3)));
        for (int r = 0; r < 6; r++) begin
            model_val = 32'hA000_0000 + 32'(r);
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                if (grant != '0) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            g = grant;
            vectors++; if (g !== exp_q[0]) begin miscompares++; $display("FAIL ct_order round=%0d got=%b exp=%b", r, g, exp_q[0]); end
            void'(exp_q.pop_front());
            if (!ok || g == '0) break;
            wait_done_port($clog2(g), ok);
            vectors++; if (!ok || done !== g) begin miscompares++; $display("FAIL ct_done round=%0d got=%b exp=%b", r, done, g); end
            vectors++; if (rdata !== 32'hA000_0000 + 32'(r)) begin miscompares++; $display("FAIL ct_rdata round=%0d got=%h exp=%h", r, rdata, 32'hA000_0000 + 32'(r)); end
            req = req & ~g;
            for (int k = 0; k < 20 && grant != '0; k++) @(negedge clk);
            if (r < 3) req = req | g;
        end
        wait_idle(ok);
        vectors++; if (!ok || req !== 3'b000) begin miscompares++; $display("FAIL ct_end got=%b exp=000", grant); end
    endtask

    task automatic test_payload_freeze();
        bit ok;
        model_lat = 8;
        model_val = 32'h0F0F_0F0F;
        set_port(1, 1'b0, 3'd2, 18'h0ABCD, 32'h0);
        req[1] = 1'b1;
        wait_start(ok);
        set_port(1, 1'b1, 3'd1, 18'h3FFFF, 32'hFFFF_FFFF);
        repeat (3) begin
            @(negedge clk);
            vectors++; if (mem_addr !== 18'h0ABCD || mem_is_write !== 1'b0) begin miscompares++; $display("FAIL pf_frozen got=%h/%b exp=0abcd/0", mem_addr, mem_is_write); end
        end
        wait_done_port(1, ok);
        vectors++; if (!ok || log_addr !== 18'h0ABCD || log_nb !== 3'd2) begin miscompares++; $display("FAIL pf_bus got=%h/%0d exp=0abcd/2", log_addr, log_nb); end
        req[1] = 1'b0;
        wait_idle(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL pf_idle got=%b exp=000", grant); end
    endtask

    task automatic test_odd_size();
        bit ok;
        model_lat = 2;
        model_val = 32'h5555_AAAA;
        set_port(2, 1'b1, 3'd3, 18'h20000, 32'h0BAD_BEEF);
        req[2] = 1'b1;
        wait_done_port(2, ok);
        vectors++; if (!ok || log_nb !== 3'd3 || log_wr !== 1'b1 || log_wdata !== 32'h0BAD_BEEF) begin miscompares++; $display("FAIL os_fwd got=%0d/%b/%h exp=3/1/0badbeef", log_nb, log_wr, log_wdata); end
        vectors++; if (grant !== 3'b100) begin miscompares++; $display("FAIL os_grant got=%b exp=100", grant); end
        req[2] = 1'b0;
        wait_idle(ok);
    endtask

    task automatic test_abandon();
        bit ok;
        bit saw_done;
        int prior;
        prior     = xfers;
        model_lat = 6;
        model_val = 32'hDEAD_0000;
        set_port(1, 1'b1, 3'd2, 18'h00400, 32'hCAFE_F00D);
        req[1] = 1'b1;
        wait_start(ok);
        repeat (2) @(negedge clk);
        req[1]   = 1'b0;
        saw_done = 1'b0;
        ok       = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done != '0) saw_done = 1'b1;
            if (grant == '0 && state_dbg == 2'd0) begin ok = 1'b1; break; end
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL ab_idle got=%b exp=000", grant); end
        vectors++; if (saw_done) begin miscompares++; $display("FAIL ab_done got=1 exp=0"); end
        vectors++; if (xfers !== prior + 1 || log_wr !== 1'b1 || log_wdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL ab_bus got=%0d/%b/%h exp=%0d/1/cafef00d", xfers, log_wr, log_wdata, prior + 1); end
        vectors++; if (rdata !== 32'h5555_AAAA) begin miscompares++; $display("FAIL ab_rdata got=%h exp=5555aaaa", rdata); end
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        model_lat = 20;
        model_val = 32'h7777_7777;
        set_port(2, 1'b0, 3'd4, 18'h10008, 32'h0);
        req[2] = 1'b1;
        wait_start(ok);
        @(negedge clk);
        rst_n  = 1'b0;
        req[2] = 1'b0;
        @(negedge clk);
        vectors++; if (grant !== 3'b000 || done !== 3'b000 || mem_start_request !== 1'b0) begin miscompares++; $display("FAIL rm_ctrl got=%b/%b/%b exp=000/000/0", grant, done, mem_start_request); end
        vectors++; if (rdata !== 32'h0 || mem_addr !== 18'h0 || state_dbg !== 2'd0) begin miscompares++; $display("FAIL rm_data got=%h/%h/%0d exp=0/0/0", rdata, mem_addr, state_dbg); end
        rst_n     = 1'b1;
        model_lat = 3;
        model_val = 32'h1357_9BDF;
        req[2]    = 1'b1;
        wait_done_port(2, ok);
        vectors++; if (!ok || rdata !== 32'h1357_9BDF || grant !== 3'b100) begin miscompares++; $display("FAIL rm_after got=%h/%b exp=13579bdf/100", rdata, grant); end
        req[2] = 1'b0;
        wait_idle(ok);
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        model_en     = 1'b0;
        model_val    = 32'hFFFF_0001;
        set_port(0, 1'b0, 3'd4, 18'h00020, 32'h0);
        start_cycles = 0;
        req[0]       = 1'b1;
        wait_done_port(0, ok);
        vectors++; if (!ok || err !== 1'b1 || rdata !== 32'h0 || done !== 3'b001) begin miscompares++; $display("FAIL to_flag got=%b/%h/%b exp=1/0/001", err, rdata, done); end
        vectors++; if (start_cycles !== 16) begin miscompares++; $display("FAIL to_cycles got=%0d exp=16", start_cycles); end
        model_en = 1'b1;
        req[0]   = 1'b0;
        wait_idle(ok);
        model_lat = 2;
        req[1]    = 1'b1;
        set_port(1, 1'b0, 3'd4, 18'h00030, 32'h0);
        wait_done_port(1, ok);
        vectors++; if (!ok || err !== 1'b0 || rdata !== 32'hFFFF_0001) begin miscompares++; $display("FAIL to_clear got=%b/%h exp=0/ffff0001", err, rdata); end
        req[1] = 1'b0;
        wait_idle(ok);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst_n         = 1'b0;
        req           = '0;
        req_is_write  = '0;
        req_num_bytes = '0;
        req_addr      = '0;
        req_wdata     = '0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_payload_freeze();
        test_odd_size();
        test_abandon();
        test_reset_mid_issue();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
